// File: rtl/video_timing_gen.sv
// Video timing and pixel-fetch generator: line/frame counters, registered pixel requests,
// and DE/HS/VS/SOF realigned to returned RGB. Define VTG_TEST_PATTERN_EN for an internal colour-bar source.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIX_LAT  = 2,
  parameter int CW       = 12
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_enable,
  output logic          o_req_valid,
  output logic [CW-1:0] o_req_x,
  output logic [CW-1:0] o_req_y,
  input  logic [23:0]   i_rgb_in,
  output logic          o_vid_de,
  output logic          o_vid_hs,
  output logic          o_vid_vs,
  output logic [7:0]    o_vid_r,
  output logic [7:0]    o_vid_g,
  output logic [7:0]    o_vid_b,
  output logic          o_sof
);

  localparam logic [CW-1:0] H_LAST = CW'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [CW-1:0] H_A0   = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] H_A1   = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] V_A0   = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] V_A1   = CW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [CW-1:0] H_S1   = CW'(H_SYNC);
  localparam logic [CW-1:0] V_S1   = CW'(V_SYNC);
  localparam logic          HS_ACT = 1'(HS_POL);
  localparam logic          VS_ACT = 1'(VS_POL);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_h, r_v, w_h_nxt, w_v_nxt;
  logic          w_last, w_run_nxt, w_req_nxt;

  logic          r_req_valid, r_hs_raw, r_vs_raw, r_sof_raw;
  logic [CW-1:0] r_req_x, r_req_y;
  logic [PIX_LAT-1:0] r_de_pipe, r_hs_pipe, r_vs_pipe, r_sof_pipe;
  logic [23:0]   w_rgb;

  assign w_last = (r_h == H_LAST) && (r_v == V_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_h     <= '0;
      r_v     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_h     <= w_h_nxt;
      r_v     <= w_v_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h;
    w_v_nxt     = r_v;
    case (r_state)
      S_IDLE:     if (i_enable) w_state_nxt = S_RUN;
      S_RUN:      if (!i_enable) w_state_nxt = S_STOPPING;
      S_STOPPING: begin
        if (i_enable)    w_state_nxt = S_RUN;
        else if (w_last) w_state_nxt = S_IDLE;
      end
      default:    w_state_nxt = S_IDLE;
    endcase
    if (r_state == S_IDLE || r_state == S_STOPPING && !i_enable && w_last) begin
      w_h_nxt = '0;
      w_v_nxt = '0;
    end else if (r_h == H_LAST) begin
      w_h_nxt = '0;
      w_v_nxt = (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end else begin
      w_h_nxt = r_h + 1'b1;
    end
  end

  // Request stage is computed from next-cycle counters so it lines up with them once registered.
  assign w_run_nxt = (w_state_nxt != S_IDLE);
  assign w_req_nxt = w_run_nxt && (w_h_nxt >= H_A0) && (w_h_nxt < H_A1) &&
                     (w_v_nxt >= V_A0) && (w_v_nxt < V_A1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_req_valid <= 1'b0;
      r_req_x     <= '0;
      r_req_y     <= '0;
      r_hs_raw    <= 1'b0;
      r_vs_raw    <= 1'b0;
      r_sof_raw   <= 1'b0;
    end else begin
      r_req_valid <= w_req_nxt;
      r_req_x     <= w_req_nxt ? w_h_nxt - H_A0 : '0;
      r_req_y     <= w_req_nxt ? w_v_nxt - V_A0 : '0;
      r_hs_raw    <= w_run_nxt && (w_h_nxt < H_S1);
      r_vs_raw    <= w_run_nxt && (w_v_nxt < V_S1);
      r_sof_raw   <= w_run_nxt && (w_h_nxt == '0) && (w_v_nxt == '0);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_de_pipe  <= '0;
      r_hs_pipe  <= '0;
      r_vs_pipe  <= '0;
      r_sof_pipe <= '0;
    end else begin
      r_de_pipe[0]  <= r_req_valid;
      r_hs_pipe[0]  <= r_hs_raw;
      r_vs_pipe[0]  <= r_vs_raw;
      r_sof_pipe[0] <= r_sof_raw;
      for (int i = 1; i < PIX_LAT; i++) begin
        r_de_pipe[i]  <= r_de_pipe[i-1];
        r_hs_pipe[i]  <= r_hs_pipe[i-1];
        r_vs_pipe[i]  <= r_vs_pipe[i-1];
        r_sof_pipe[i] <= r_sof_pipe[i-1];
      end
    end
  end

`ifdef VTG_TEST_PATTERN_EN
  localparam logic [CW-1:0] BAR_W = CW'((H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1);
  logic [CW-1:0] r_x_pipe [PIX_LAT];
  logic [CW-1:0] w_bar_idx;
  logic [23:0]   w_bar_rgb;
  logic          w_unused_rgb;

  assign w_unused_rgb = ^i_rgb_in;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < PIX_LAT; i++) r_x_pipe[i] <= '0;
    end else begin
      r_x_pipe[0] <= r_req_x;
      for (int i = 1; i < PIX_LAT; i++) r_x_pipe[i] <= r_x_pipe[i-1];
    end
  end

  assign w_bar_idx = r_x_pipe[PIX_LAT-1] / BAR_W;

  always_comb begin
    w_bar_rgb = 24'h000000;
    case (w_bar_idx)
      CW'(0):  w_bar_rgb = 24'hFFFFFF;
      CW'(1):  w_bar_rgb = 24'hFFFF00;
      CW'(2):  w_bar_rgb = 24'h00FFFF;
      CW'(3):  w_bar_rgb = 24'h00FF00;
      CW'(4):  w_bar_rgb = 24'hFF00FF;
      CW'(5):  w_bar_rgb = 24'hFF0000;
      CW'(6):  w_bar_rgb = 24'h0000FF;
      default: w_bar_rgb = 24'h000000;
    endcase
  end

  assign w_rgb = r_de_pipe[PIX_LAT-1] ? w_bar_rgb : 24'h000000;
`else
  assign w_rgb = r_de_pipe[PIX_LAT-1] ? i_rgb_in : 24'h000000;
`endif

  assign o_req_valid = r_req_valid;
  assign o_req_x     = r_req_x;
  assign o_req_y     = r_req_y;
  assign o_vid_de    = r_de_pipe[PIX_LAT-1];
  assign o_vid_hs    = r_hs_pipe[PIX_LAT-1] ? HS_ACT : ~HS_ACT;
  assign o_vid_vs    = r_vs_pipe[PIX_LAT-1] ? VS_ACT : ~VS_ACT;
  assign o_sof       = r_sof_pipe[PIX_LAT-1];
  assign o_vid_r     = w_rgb[23:16];
  assign o_vid_g     = w_rgb[15:8];
  assign o_vid_b     = w_rgb[7:0];

endmodule
